// File: rtl/fb_scanout.sv
// Frame-buffer scanout: 640x480@60 VGA timing over a pixel-doubled 320x240 RGB444 buffer.
// Owns the double-buffer select and swaps displayed/drawn buffers at the start of vblank.
module fb_scanout #(
  parameter int FB_W     = 320,
  parameter int FB_H     = 240,
  parameter int H_ACT    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACT    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [16:0] o_fb_addr,
  output logic        o_fb_sel,
  input  logic [11:0] i_fb_data,
  input  logic        i_swap_req,
  output logic        o_swap_ack,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic [3:0]  o_vga_r,
  output logic [3:0]  o_vga_g,
  output logic [3:0]  o_vga_b,
  output logic        o_vblank
);

  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  // Row base stops advancing on the last displayed line pair, and never past the stored rows.
  localparam int V_ROW_END = ((V_ACT < 2 * FB_H) ? V_ACT : 2 * FB_H) - 1;

  localparam logic [HW-1:0] H_ACT_C   = HW'(H_ACT);
  localparam logic [HW-1:0] H_LAST_C  = HW'(H_TOT - 1);
  localparam logic [HW-1:0] HS_BEG_C  = HW'(H_ACT + H_FP);
  localparam logic [HW-1:0] HS_END_C  = HW'(H_ACT + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_ACT_C   = VW'(V_ACT);
  localparam logic [VW-1:0] V_LAST_C  = VW'(V_TOT - 1);
  localparam logic [VW-1:0] VS_BEG_C  = VW'(V_ACT + V_FP);
  localparam logic [VW-1:0] VS_END_C  = VW'(V_ACT + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_ROW_C   = VW'(V_ROW_END);
  localparam logic [16:0]   FB_W_C    = 17'(FB_W);
  localparam logic          SYNC_ACT  = (SYNC_POL != 0);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [16:0]   row_base;
  logic          swap_pend;
  logic          act_d;
  logic          hs_d;
  logic          vs_d;

  logic h_last, v_last, active, hs_act, vs_act, swap_pt;

  always_comb begin
    h_last  = (h_cnt == H_LAST_C);
    v_last  = (v_cnt == V_LAST_C);
    active  = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    hs_act  = (h_cnt >= HS_BEG_C) && (h_cnt < HS_END_C);
    vs_act  = (v_cnt >= VS_BEG_C) && (v_cnt < VS_END_C);
    swap_pt = (h_cnt == '0) && (v_cnt == V_ACT_C);
  end

  assign o_vblank = (v_cnt >= V_ACT_C);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_cnt      <= '0;
      v_cnt      <= '0;
      row_base   <= '0;
      o_fb_addr  <= '0;
      o_fb_sel   <= 1'b0;
      swap_pend  <= 1'b0;
      o_swap_ack <= 1'b0;
      act_d      <= 1'b0;
      hs_d       <= 1'b0;
      vs_d       <= 1'b0;
      o_vga_r    <= '0;
      o_vga_g    <= '0;
      o_vga_b    <= '0;
      o_hsync    <= ~SYNC_ACT;
      o_vsync    <= ~SYNC_ACT;
    end else begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        if (v_last)
          row_base <= '0;
        else if (v_cnt[0] && (v_cnt < V_ROW_C))
          row_base <= row_base + FB_W_C;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end

      // Stage 1: address and aligned control flags.
      if (active)
        o_fb_addr <= row_base + 17'(h_cnt >> 1);
      act_d <= active;
      hs_d  <= hs_act;
      vs_d  <= vs_act;

      // Stage 2: colour capture and sync outputs.
      {o_vga_r, o_vga_g, o_vga_b} <= act_d ? i_fb_data : 12'h000;
      o_hsync <= hs_d ? SYNC_ACT : ~SYNC_ACT;
      o_vsync <= vs_d ? SYNC_ACT : ~SYNC_ACT;

      // A request arriving on the swap clock itself is folded into that swap.
      o_swap_ack <= 1'b0;
      if (swap_pt && (swap_pend || i_swap_req)) begin
        o_fb_sel   <= ~o_fb_sel;
        swap_pend  <= 1'b0;
        o_swap_ack <= 1'b1;
      end else if (i_swap_req) begin
        swap_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout on a scaled-down timing so several full frames fit in the run.
// The driver predicts each cycle's outputs from raster position arithmetic; a monitor compares.
module tb_fb_scanout;

  localparam int FB_W = 20, FB_H = 15;
  localparam int H_ACT = 40, H_FP = 4, H_SYNC = 8, H_BP = 8;
  localparam int V_ACT = 30, V_FP = 3, V_SYNC = 2, V_BP = 5;
  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int NPIX  = FB_W * FB_H;
  localparam int N_CYC = 30000;

  typedef struct packed {
    logic [16:0] addr;
    logic        sel;
    logic        ack;
    logic        hs;
    logic        vs;
    logic        vb;
    logic [11:0] rgb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        swap_req = 1'b0;
  logic [16:0] fb_addr;
  logic        fb_sel;
  logic [11:0] fb_data;
  logic        swap_ack, hsync, vsync, vblank;
  logic [3:0]  vga_r, vga_g, vga_b;

  logic [11:0] mem [NPIX];
  exp_t        expq[$];
  int          n_checks = 0;
  int          n_pass = 0;
  bit          running = 0;

  // Model state
  int   n = 0;
  int   ex_addr = 0;
  bit   m_sel = 0, m_pend = 0, m_ack = 0, done_rst = 0;
  bit   r, q;
  int   h, v, f;
  exp_t e;

  always #5 clk = ~clk;

  assign fb_data = (int'(fb_addr) < NPIX) ? mem[int'(fb_addr)] : 12'h000;

  fb_scanout #(
    .FB_W(FB_W), .FB_H(FB_H),
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(0)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .o_fb_addr(fb_addr),
    .o_fb_sel(fb_sel),
    .i_fb_data(fb_data),
    .i_swap_req(swap_req),
    .o_swap_ack(swap_ack),
    .o_hsync(hsync),
    .o_vsync(vsync),
    .o_vga_r(vga_r),
    .o_vga_g(vga_g),
    .o_vga_b(vga_b),
    .o_vblank(vblank)
  );

  function automatic int hpos(input int k);
    return k % H_TOT;
  endfunction

  function automatic int vpos(input int k);
    return (k / H_TOT) % V_TOT;
  endfunction

  function automatic bit is_act(input int k);
    return (hpos(k) < H_ACT) && (vpos(k) < V_ACT);
  endfunction

  function automatic int pix(input int k);
    return (vpos(k) / 2) * FB_W + hpos(k) / 2;
  endfunction

  task automatic chk(input string nm, input logic [16:0] act, input logic [16:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, want, $time);
  endtask

  // Driver + reference model: n counts clocks since the last reset.
  initial begin
    for (int i = 0; i < NPIX; i++) mem[i] = 12'($urandom);
    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge clk);
      h = hpos(n);
      v = vpos(n);
      f = n / FRAME;
      r = (cyc < 3);
      q = 1'b0;
      if (!done_rst) begin
        if (f == 0 && h == 25 && v == 12) q = 1'b1;
        if (f == 1 && ((h == 3 && v == 2) || (h == 50 && v == 20))) q = 1'b1;
        if (f == 2 && h == 0 && v == V_ACT) q = 1'b1;
        if (f == 3 && h == 1 && v == V_ACT) q = 1'b1;
        if (f == 5 && h == 10 && v == 5) q = 1'b1;
        if (f == 5 && h == 30 && v == 20) begin
          r = 1'b1;
          done_rst = 1'b1;
        end
      end else if (cyc >= 3) begin
        if (n > V_ACT * H_TOT) q = ($urandom_range(0, 799) == 0);
        if ($urandom_range(0, 4999) == 0) r = 1'b1;
      end
      rst = r;
      swap_req = q;

      if (r) begin
        n = 0; m_sel = 0; m_pend = 0; m_ack = 0; ex_addr = 0;
      end else begin
        if (is_act(n)) ex_addr = pix(n);
        m_ack = 0;
        if (h == 0 && v == V_ACT && (m_pend || q)) begin
          m_sel = !m_sel;
          m_pend = 0;
          m_ack = 1;
        end else if (q) begin
          m_pend = 1;
        end
        n++;
      end

      e.addr = 17'(ex_addr);
      e.sel  = m_sel;
      e.ack  = m_ack;
      e.vb   = (vpos(n) >= V_ACT);
      e.hs   = !(n >= 2 && hpos(n-2) >= H_ACT + H_FP && hpos(n-2) < H_ACT + H_FP + H_SYNC);
      e.vs   = !(n >= 2 && vpos(n-2) >= V_ACT + V_FP && vpos(n-2) < V_ACT + V_FP + V_SYNC);
      e.rgb  = (n >= 2 && is_act(n-2)) ? mem[pix(n-2)] : 12'h000;
      expq.push_back(e);
      running = 1;
    end
    @(negedge clk);
    running = 0;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Monitor: outputs are valid every clock, so one expectation is consumed per clock.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        x = expq.pop_front();
        chk("fb_addr",  fb_addr, x.addr);
        chk("fb_sel",   17'(fb_sel), 17'(x.sel));
        chk("swap_ack", 17'(swap_ack), 17'(x.ack));
        chk("hsync",    17'(hsync), 17'(x.hs));
        chk("vsync",    17'(vsync), 17'(x.vs));
        chk("vblank",   17'(vblank), 17'(x.vb));
        chk("rgb",      17'({vga_r, vga_g, vga_b}), 17'(x.rgb));
      end else if (running) begin
        n_checks++;
        $display("FAIL scoreboard: got empty queue, expected one entry at %0t", $time);
      end
    end
  end

endmodule
